alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 212 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle logic/arithmetic ops plus multi-cycle
// unsigned shift-add multiply and restoring divide (one bit per clock).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only in IDLE
//   instr               opcode (zero-extended when IWIDTH > 4)
//   in_a, in_b          operands, captured with start
//   alu_c_in, alu_b_in  carry in (ADD), borrow in (SUB)
//   busy                MUL/DIV iteration in progress
//   done                one-cycle pulse, results valid from this cycle on
//   alu_out, alu_out_hi primary result; MUL high half / DIV remainder
//   alu_c_out, alu_b_out, alu_z_out  carry, borrow, zero flags
//   alu_flag_valid      carry/borrow meaningful (ADD, SUB, INC, DEC)
//   div_err             last op was DIV by zero
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IWIDTH-1:0] instr,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              alu_c_in,
  input  logic              alu_b_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  alu_out,
  output logic [WIDTH-1:0]  alu_out_hi,
  output logic              alu_c_out,
  output logic              alu_b_out,
  output logic              alu_z_out,
  output logic              alu_flag_valid,
  output logic              div_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] work_lo_reg;   // MUL: multiplier shifting out / DIV: dividend -> quotient
  logic [WIDTH-1:0] work_hi_reg;   // MUL: partial product high / DIV: remainder
  logic [WIDTH-1:0] op_b_reg;

  logic [WIDTH-1:0] out_reg, hi_reg;
  logic             c_reg, b_reg, z_reg, fv_reg, err_reg;

  // ---------------- single-cycle datapath ----------------
  logic [7:0]       op8;
  logic             is_mul, is_div, div_zero, multi;
  logic [WIDTH:0]   ext_a, ext_b, arith;
  logic [WIDTH-1:0] sc_out, sc_hi;
  logic             sc_c, sc_b, sc_fv, sc_err;

  always_comb begin
    op8      = 8'(instr);
    ext_a    = {1'b0, in_a};
    ext_b    = {1'b0, in_b};
    is_mul   = (op8 == 8'h0B);
    is_div   = (op8 == 8'h0C);
    div_zero = is_div && (in_b == '0);
    multi    = is_mul || (is_div && !div_zero);
    arith    = '0;
    sc_out   = in_b;
    sc_hi    = '0;
    sc_c     = 1'b0;
    sc_b     = 1'b0;
    sc_fv    = 1'b0;
    sc_err   = 1'b0;
    case (op8)
      8'h01: sc_out = ~in_a;
      8'h02: sc_out = in_a ^ in_b;
      8'h03: sc_out = in_a | in_b;
      8'h04: sc_out = in_a & in_b;
      8'h05: begin
        arith  = ext_a - ext_b - (WIDTH+1)'(alu_b_in);
        sc_out = arith[WIDTH-1:0];
        sc_b   = arith[WIDTH];          // wrapped below zero
        sc_fv  = 1'b1;
      end
      8'h06: begin
        arith  = ext_a + ext_b + (WIDTH+1)'(alu_c_in);
        sc_out = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
        sc_fv  = 1'b1;
      end
      8'h07: sc_out = in_a >> 1;
      8'h08: sc_out = in_a << 1;
      8'h09: begin
        arith  = ext_a - (WIDTH+1)'(1);
        sc_out = arith[WIDTH-1:0];
        sc_b   = arith[WIDTH];
        sc_fv  = 1'b1;
      end
      8'h0A: begin
        arith  = ext_a + (WIDTH+1)'(1);
        sc_out = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
        sc_fv  = 1'b1;
      end
      8'h0C: begin
        // Only reaches the output registers for the divide-by-zero case.
        sc_out = '1;
        sc_hi  = in_a;
        sc_err = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- iteration datapath ----------------
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic             last_iter;

  always_comb begin
    // MUL: add multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole product right by one.
    mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, op_b_reg} : '0);
    // DIV: bring the next dividend bit into the remainder and trial-subtract.
    div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_b_reg};
    if (state_reg == S_MUL) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      it_hi = div_diff[WIDTH-1:0];
      it_lo = {work_lo_reg[WIDTH-2:0], 1'b1};
    end else begin
      it_hi = div_shift[WIDTH-1:0];
      it_lo = {work_lo_reg[WIDTH-2:0], 1'b0};
    end
    last_iter = (cnt_reg == CW'(WIDTH-1));
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = is_mul ? S_MUL : (multi ? S_DIV : S_DONE);
      S_MUL, S_DIV: if (last_iter) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      work_lo_reg <= '0;
      work_hi_reg <= '0;
      op_b_reg    <= '0;
      out_reg     <= '0;
      hi_reg      <= '0;
      c_reg       <= 1'b0;
      b_reg       <= 1'b0;
      z_reg       <= 1'b0;
      fv_reg      <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: if (start) begin
          work_lo_reg <= in_a;
          work_hi_reg <= '0;
          op_b_reg    <= in_b;
          cnt_reg     <= '0;
          if (!multi) begin
            out_reg <= sc_out;
            hi_reg  <= sc_hi;
            c_reg   <= sc_c;
            b_reg   <= sc_b;
            fv_reg  <= sc_fv;
            err_reg <= sc_err;
            z_reg   <= (sc_out == '0);
          end
        end
        S_MUL, S_DIV: begin
          work_lo_reg <= it_lo;
          work_hi_reg <= it_hi;
          cnt_reg     <= cnt_reg + 1'b1;
          if (last_iter) begin
            out_reg <= it_lo;
            hi_reg  <= it_hi;
            c_reg   <= 1'b0;
            b_reg   <= 1'b0;
            fv_reg  <= 1'b0;
            err_reg <= 1'b0;
            // MUL zero flag covers the full double-width product.
            z_reg   <= (state_reg == S_MUL) ? ({it_hi, it_lo} == '0) : (it_lo == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state_reg == S_MUL) || (state_reg == S_DIV);
  assign done           = (state_reg == S_DONE);
  assign alu_out        = out_reg;
  assign alu_out_hi     = hi_reg;
  assign alu_c_out      = c_reg;
  assign alu_b_out      = b_reg;
  assign alu_z_out      = z_reg;
  assign alu_flag_valid = fv_reg;
  assign div_err        = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8, IWIDTH=4): directed vector table, hand-written
// multi-cycle sequences (ignored second start, reset mid-MUL), and random ops
// checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, alu_c_in, alu_b_in;
  logic [3:0]   instr;
  logic [W-1:0] in_a, in_b;
  logic         busy, done, alu_c_out, alu_b_out, alu_z_out, alu_flag_valid, div_err;
  logic [W-1:0] alu_out, alu_out_hi;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .IWIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .in_a(in_a), .in_b(in_b), .alu_c_in(alu_c_in), .alu_b_in(alu_b_in),
    .busy(busy), .done(done), .alu_out(alu_out), .alu_out_hi(alu_out_hi),
    .alu_c_out(alu_c_out), .alu_b_out(alu_b_out), .alu_z_out(alu_z_out),
    .alu_flag_valid(alu_flag_valid), .div_err(div_err)
  );

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic c, b, z, fv, err;
    int   lat;
  } res_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic       ci, bi;
    res_t       e;
  } vec_t;

  task automatic chk(input string tag, input string what, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, b,
                                 input logic ci, bi);
    res_t r;
    int   ia = int'(a), ib = int'(b), t;
    int   lim = 1 << W;
    r = '{out: '0, hi: '0, c: 0, b: 0, z: 0, fv: 0, err: 0, lat: 1};
    case (op)
      4'h1: r.out = W'(lim - 1 - ia);
      4'h2: r.out = a ^ b;
      4'h3: r.out = a | b;
      4'h4: r.out = a & b;
      4'h5: begin t = ia - ib - int'(bi); r.b = (t < 0); r.out = W'(t < 0 ? t + lim : t); r.fv = 1; end
      4'h6: begin t = ia + ib + int'(ci); r.c = (t >= lim); r.out = W'(t % lim); r.fv = 1; end
      4'h7: r.out = W'(ia / 2);
      4'h8: r.out = W'((ia * 2) % lim);
      4'h9: begin t = ia - 1; r.b = (t < 0); r.out = W'(t < 0 ? t + lim : t); r.fv = 1; end
      4'hA: begin t = ia + 1; r.c = (t >= lim); r.out = W'(t % lim); r.fv = 1; end
      4'hB: begin t = ia * ib; r.out = W'(t % lim); r.hi = W'(t / lim); r.lat = W + 1; end
      4'hC: begin
        if (ib == 0) begin r.out = W'(lim - 1); r.hi = a; r.err = 1; end
        else begin r.out = W'(ia / ib); r.hi = W'(ia % ib); r.lat = W + 1; end
      end
      default: r.out = b;
    endcase
    r.z = (op == 4'hB) ? (ia * ib == 0) : (r.out == 0);
    return r;
  endfunction

  function automatic vec_t mk(input string n, input logic [3:0] op, input logic [W-1:0] a, b,
                              input logic ci, bi, input logic [W-1:0] eo, eh,
                              input logic ec, eb, ez, efv, eerr, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.ci = ci; v.bi = bi;
    v.e = '{out: eo, hi: eh, c: ec, b: eb, z: ez, fv: efv, err: eerr, lat: lat};
    return v;
  endfunction

  task automatic chk_outputs(input string tag, input res_t e);
    chk(tag, "out", alu_out, e.out);
    chk(tag, "hi", alu_out_hi, e.hi);
    chk(tag, "c", alu_c_out, e.c);
    chk(tag, "b", alu_b_out, e.b);
    chk(tag, "z", alu_z_out, e.z);
    chk(tag, "fv", alu_flag_valid, e.fv);
    chk(tag, "err", div_err, e.err);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, "busy", busy, 0);
    chk(tag, "done", done, 0);
    chk_outputs(tag, '{out: '0, hi: '0, c: 0, b: 0, z: 0, fv: 0, err: 0, lat: 0});
  endtask

  // Issue one op, scramble inputs after the start edge, wait (bounded) for done,
  // then check latency, busy cycles, results, the single-cycle done pulse and hold.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, b,
                        input logic ci, bi, input res_t e);
    int lat, bsy;
    instr = op; in_a = a; in_b = b; alu_c_in = ci; alu_b_in = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); instr = 4'($urandom);
    alu_c_in = 1'($urandom); alu_b_in = 1'($urandom);
    lat = 1; bsy = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    chk(tag, "latency", lat, e.lat);
    chk(tag, "busy_cycles", bsy, e.lat - 1);
    chk_outputs(tag, e);
    $display("op=%h a=%h b=%h ci=%0b bi=%0b -> out=%h hi=%h c=%0b b=%0b z=%0b fv=%0b err=%0b lat=%0d [%s]",
             op, a, b, ci, bi, alu_out, alu_out_hi, alu_c_out, alu_b_out, alu_z_out,
             alu_flag_valid, div_err, lat, tag);
    @(posedge clk); #1;
    chk(tag, "done_pulse", done, 0);
    chk(tag, "hold_out", alu_out, e.out);
  endtask

  vec_t vt[19];
  res_t r;

  initial begin
    int lat, dn;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic ci, bi;

    vt[0]  = mk("add_ff_01", 4'h6, 8'hFF, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 1, 1, 0, 1);
    vt[1]  = mk("sub_00_01", 4'h5, 8'h00, 8'h01, 0, 1, 8'hFE, 8'h00, 0, 1, 0, 1, 0, 1);
    vt[2]  = mk("mul_ff_ff", 4'hB, 8'hFF, 8'hFF, 0, 0, 8'h01, 8'hFE, 0, 0, 0, 0, 0, 9);
    vt[3]  = mk("div_64_07", 4'hC, 8'h64, 8'h07, 0, 0, 8'h0E, 8'h02, 0, 0, 0, 0, 0, 9);
    vt[4]  = mk("div_12_00", 4'hC, 8'h12, 8'h00, 0, 0, 8'hFF, 8'h12, 0, 0, 0, 0, 1, 1);
    vt[5]  = mk("pass_f",    4'hF, 8'h33, 8'h5A, 1, 1, 8'h5A, 8'h00, 0, 0, 0, 0, 0, 1);
    vt[6]  = mk("inc_ff",    4'hA, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 1, 0, 1);
    vt[7]  = mk("dec_00",    4'h9, 8'h00, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 1, 0, 1, 0, 1);
    vt[8]  = mk("rl_81",     4'h8, 8'h81, 8'h00, 0, 0, 8'h02, 8'h00, 0, 0, 0, 0, 0, 1);
    vt[9]  = mk("rr_81",     4'h7, 8'h81, 8'h00, 0, 0, 8'h40, 8'h00, 0, 0, 0, 0, 0, 1);
    vt[10] = mk("mul_00_37", 4'hB, 8'h00, 8'h37, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 9);
    vt[11] = mk("div_05_09", 4'hC, 8'h05, 8'h09, 0, 0, 8'h00, 8'h05, 0, 0, 1, 0, 0, 9);
    vt[12] = mk("not_ff",    4'h1, 8'hFF, 8'h12, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 1);
    vt[13] = mk("xor",       4'h2, 8'hA5, 8'h5A, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 1);
    vt[14] = mk("or",        4'h3, 8'hA0, 8'h05, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 0, 0, 1);
    vt[15] = mk("and",       4'h4, 8'hF0, 8'h3C, 0, 0, 8'h30, 8'h00, 0, 0, 0, 0, 0, 1);
    vt[16] = mk("add_ci",    4'h6, 8'h10, 8'h20, 1, 0, 8'h31, 8'h00, 0, 0, 0, 1, 0, 1);
    vt[17] = mk("mul_10_10", 4'hB, 8'h10, 8'h10, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0, 0, 9);
    vt[18] = mk("pass_0",    4'h0, 8'h11, 8'h22, 0, 0, 8'h22, 8'h00, 0, 0, 0, 0, 0, 1);

    rst_n = 1'b0; start = 1'b0; instr = '0; in_a = '0; in_b = '0;
    alu_c_in = 1'b0; alu_b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");

    // Start on the very first rising edge after reset release.
    @(negedge clk) rst_n = 1'b1;
    run_op("first_after_reset", 4'h6, 8'h02, 8'h03, 0, 0,
           '{out: 8'h05, hi: 0, c: 0, b: 0, z: 0, fv: 1, err: 0, lat: 1});

    foreach (vt[i]) run_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].ci, vt[i].bi, vt[i].e);

    // MUL with a second start raised at cycle 3: must be ignored and not queued.
    instr = 4'hB; in_a = 8'hFF; in_b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (!done && lat < 40) begin
      if (lat == 3) begin start = 1'b1; instr = 4'h6; in_a = 8'h01; in_b = 8'h01; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("mul_restart", "latency", lat, 9);
    chk_outputs("mul_restart", '{out: 8'h01, hi: 8'hFE, c: 0, b: 0, z: 0, fv: 0, err: 0, lat: 9});
    dn = 0;
    repeat (5) begin @(posedge clk); #1; if (done) dn++; end
    chk("mul_restart", "no_queued_done", dn, 0);
    $display("op=b a=ff b=ff with ignored start at cycle 3 -> out=%h hi=%h lat=%0d [mul_restart]",
             alu_out, alu_out_hi, lat);

    // Reset asserted at cycle 4 of a MUL: outputs clear at once, no done follows.
    instr = 4'hB; in_a = 8'hFF; in_b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_mid_mul");
    @(negedge clk); @(negedge clk) rst_n = 1'b1;
    dn = 0;
    repeat (12) begin @(posedge clk); #1; if (done) dn++; end
    chk("reset_mid_mul", "no_done", dn, 0);
    $display("reset during mul: done pulses after release=%0d [reset_mid_mul]", dn);
    run_op("add_after_reset", 4'h6, 8'h02, 8'h03, 0, 0,
           '{out: 8'h05, hi: 0, c: 0, b: 0, z: 0, fv: 1, err: 0, lat: 1});

    // Random ops against the reference model (MUL/DIV weighted up).
    for (int k = 0; k < 120; k++) begin
      op = (k % 4 == 0) ? 4'($urandom_range(11, 12)) : 4'($urandom);
      a  = W'($urandom);
      b  = ($urandom_range(0, 9) == 0) ? 8'h00 : W'($urandom);
      ci = 1'($urandom); bi = 1'($urandom);
      r  = model(op, a, b, ci, bi);
      run_op($sformatf("rand%0d", k), op, a, b, ci, bi, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
